mem_arbiter: RTL and testbench

- Two-requester arbiter in front of the 256x8 single-port synchronous memory.
- Shares the memory between port A (CPU fetch/load/store) and port B (program loader/debug).
- Serialises accesses and drives the memory's write_enable/address/write_data.
- Captures the one-cycle-late read_data and returns it to the granted requester with a valid pulse.

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port synchronous memory (read data one edge late).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module mem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;        // 0 = port A, 1 = port B
   logic          a_gnt_q, a_gnt_d;
   logic          b_gnt_q, b_gnt_d;
   logic          a_rvalid_q, a_rvalid_d;
   logic          b_rvalid_q, b_rvalid_d;
   logic [DW-1:0] a_rdata_q, a_rdata_d;
   logic [DW-1:0] b_rdata_q, b_rdata_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          busy_q, busy_d;
   logic          win_b_s;
`ifdef MEM_ARB_RR_EN
   logic          last_grant_q, last_grant_d;
`endif

   // Winner selection among the currently asserted requests.
   always_comb begin
`ifdef MEM_ARB_RR_EN
      if (a_req && b_req) begin
         win_b_s = ~last_grant_q;
      end else begin
         win_b_s = b_req;
      end
`else
      win_b_s = b_req & ~a_req;
`endif
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      a_gnt_d     = 1'b0;
      b_gnt_d     = 1'b0;
      a_rvalid_d  = 1'b0;
      b_rvalid_d  = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               state_d = ISSUE;
               owner_d = win_b_s;
`ifdef MEM_ARB_RR_EN
               last_grant_d = win_b_s;
`endif
               if (win_b_s) begin
                  b_gnt_d     = 1'b1;
                  mem_we_d    = b_we;
                  mem_addr_d  = b_addr;
                  mem_wdata_d = b_wdata;
               end else begin
                  a_gnt_d     = 1'b1;
                  mem_we_d    = a_we;
                  mem_addr_d  = a_addr;
                  mem_wdata_d = a_wdata;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            // Memory output now holds the contents from before any write at ISSUE.
            state_d = IDLE;
            if (owner_q) begin
               b_rdata_d  = mem_rdata;
               b_rvalid_d = 1'b1;
            end else begin
               a_rdata_d  = mem_rdata;
               a_rvalid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         a_gnt_q     <= 1'b0;
         b_gnt_q     <= 1'b0;
         a_rvalid_q  <= 1'b0;
         b_rvalid_q  <= 1'b0;
         a_rdata_q   <= {DW{1'b0}};
         b_rdata_q   <= {DW{1'b0}};
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {AW{1'b0}};
         mem_wdata_q <= {DW{1'b0}};
         busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         a_gnt_q     <= a_gnt_d;
         b_gnt_q     <= b_gnt_d;
         a_rvalid_q  <= a_rvalid_d;
         b_rvalid_q  <= b_rvalid_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign a_gnt     = a_gnt_q;
   assign b_gnt     = b_gnt_q;
   assign a_rvalid  = a_rvalid_q;
   assign b_rvalid  = b_rvalid_q;
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a memory model and a
// transaction-level reference model (grant edge + fixed 3-edge access timeline).
module tb_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          a_req = 1'b0, a_we = 1'b0;
   logic [AW-1:0] a_addr = 8'h00;
   logic [DW-1:0] a_wdata = 8'h00;
   logic          b_req = 1'b0, b_we = 1'b0;
   logic [AW-1:0] b_addr = 8'h00;
   logic [DW-1:0] b_wdata = 8'h00;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_load = 1'b1;
   logic [DW-1:0] phys_mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: one outstanding access described by its grant edge.
   int            e = 0;
   int            g_edge = -100;
   logic          g_port = 1'b0;
   logic          g_we = 1'b0;
   logic [7:0]    g_data = 8'h00;
   logic          lg = 1'b1;
   logic [7:0]    ex_rdata_a = 8'h00, ex_rdata_b = 8'h00;
   logic [7:0]    ex_mem_addr = 8'h00, ex_mem_wdata = 8'h00;
   logic [7:0]    ref_mem [256];

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   function automatic logic [7:0] init_val(input int i);
      return 8'((i * 7 + 113) & 255);
   endfunction

   // Single-port synchronous memory: read returns contents before a same-edge write.
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 256; i++) phys_mem[i] <= init_val(i);
      end else if (mem_we) begin
         phys_mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= phys_mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic model_reset();
      g_edge = -100; g_port = 1'b0; g_we = 1'b0; g_data = 8'h00; lg = 1'b1;
      ex_rdata_a = 8'h00; ex_rdata_b = 8'h00; ex_mem_addr = 8'h00; ex_mem_wdata = 8'h00;
   endtask

   // Advance the model by one rising edge using the inputs present at that edge.
   task automatic model_step();
      logic pick_b;
      if (e >= g_edge + 3 && (a_req || b_req)) begin
         pick_b       = b_req && (!a_req || (RR && !lg));
         g_edge       = e;
         g_port       = pick_b;
         g_we         = pick_b ? b_we : a_we;
         ex_mem_addr  = pick_b ? b_addr : a_addr;
         ex_mem_wdata = pick_b ? b_wdata : a_wdata;
         g_data       = ref_mem[ex_mem_addr];
         if (g_we) ref_mem[ex_mem_addr] = ex_mem_wdata;
         lg = pick_b;
      end
      if (e == g_edge + 2) begin
         if (g_port) ex_rdata_b = g_data;
         else        ex_rdata_a = g_data;
      end
   endtask

   task automatic check_outputs();
      check("a_gnt",     32'(a_gnt),     32'((e == g_edge) && !g_port));
      check("b_gnt",     32'(b_gnt),     32'((e == g_edge) && g_port));
      check("a_rvalid",  32'(a_rvalid),  32'((e == g_edge + 2) && !g_port));
      check("b_rvalid",  32'(b_rvalid),  32'((e == g_edge + 2) && g_port));
      check("a_rdata",   32'(a_rdata),   32'(ex_rdata_a));
      check("b_rdata",   32'(b_rdata),   32'(ex_rdata_b));
      check("mem_we",    32'(mem_we),    32'((e == g_edge) && g_we));
      check("mem_addr",  32'(mem_addr),  32'(ex_mem_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(ex_mem_wdata));
      check("busy",      32'(busy),      32'((e == g_edge) || (e == g_edge + 1)));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      e++;
      model_step();
      check_outputs();
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
      model_reset();
      #1;
      check_outputs();
      repeat (cycles) step();
      rst = 1'b0;
   endtask

   function automatic logic [7:0] rand_addr();
      int sel = int'($urandom_range(3, 0));
      if (sel == 0) return 8'hFF;
      if (sel == 1) return 8'($urandom_range(3, 0));
      return 8'($urandom_range(255, 0));
   endfunction

   initial begin
      int first;
      int cnt_a;
      int cnt_b;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      #2;
      do_reset(2);
      mem_load = 1'b0;

      // Read of address 0 right after reset.
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h33;
      step();
      check("t1_gnt", 32'(a_gnt), 32'd1);
      check("t1_we", 32'(mem_we), 32'd0);
      check("t1_busy1", 32'(busy), 32'd1);
      a_req = 1'b0;
      step();
      check("t1_busy2", 32'(busy), 32'd1);
      step();
      check("t1_rvalid", 32'(a_rvalid), 32'd1);
      check("t1_rdata", 32'(a_rdata), 32'h71);
      check("t1_busy3", 32'(busy), 32'd0);

      // B write returns old data; A then reads the new value.
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'h0F; b_wdata = 8'h5A;
      step();
      check("t2_we_on", 32'(mem_we), 32'd1);
      b_req = 1'b0;
      step();
      check("t2_we_off", 32'(mem_we), 32'd0);
      step();
      check("t2_b_rvalid", 32'(b_rvalid), 32'd1);
      check("t2_b_old", 32'(b_rdata), 32'hDA);
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h0F;
      step();
      a_req = 1'b0;
      step();
      step();
      check("t2_a_new", 32'(a_rdata), 32'h5A);

      // Simultaneous requests.
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
      b_req = 1'b1; b_we = 1'b0; b_addr = 8'h03;
      first = 2;
      for (int i = 0; i < 9; i++) begin
         step();
         if (a_gnt) begin a_req = 1'b0; if (first == 2) first = 0; end
         if (b_gnt) begin b_req = 1'b0; if (first == 2) first = 1; end
      end
      check("t3_served", 32'(a_req | b_req), 32'd0);
`ifdef MEM_ARB_RR_EN
      check("t3_first", 32'(first), 32'd1);
`else
      check("t3_first", 32'(first), 32'd0);
`endif
      check("t3_b_rdata", 32'(b_rdata), 32'h86);

      // Continuous simultaneous requests over four accesses.
      a_req = 1'b1; a_addr = 8'h10; b_req = 1'b1; b_addr = 8'h20;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (a_gnt) cnt_a++;
         if (b_gnt) cnt_b++;
      end
      a_req = 1'b0; b_req = 1'b0;
`ifdef MEM_ARB_RR_EN
      check("t4_cnt_a", 32'(cnt_a), 32'd2);
      check("t4_cnt_b", 32'(cnt_b), 32'd2);
`else
      check("t4_cnt_a", 32'(cnt_a), 32'd4);
      check("t4_cnt_b", 32'(cnt_b), 32'd0);
`endif
      step();

      // Reset during CAPTURE of an A read.
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h22;
      step();
      a_req = 1'b0;
      step();
      do_reset(2);
      a_req = 1'b1;
      step();
      check("t5_gnt", 32'(a_gnt), 32'd1);
      a_req = 1'b0;
      step();
      step();
      check("t5_rdata", 32'(a_rdata), 32'h5F);

      // Top address write then read.
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'hFF; a_wdata = 8'hFF;
      step();
      check("t6_addr", 32'(mem_addr), 32'hFF);
      a_req = 1'b0;
      step();
      step();
      check("t6_old", 32'(a_rdata), 32'h6A);
      a_req = 1'b1; a_we = 1'b0;
      step();
      a_req = 1'b0;
      step();
      step();
      check("t6_new", 32'(a_rdata), 32'hFF);
      check("t6_b_rdata", 32'(b_rdata), 32'h00);

      // Random traffic with occasional resets outside the ISSUE cycle.
      for (int c = 0; c < 900; c++) begin
         step();
         if (a_req && e == g_edge && !g_port) a_req = 1'b0;
         if (b_req && e == g_edge && g_port)  b_req = 1'b0;
         if (!a_req && $urandom_range(2, 0) == 0) begin
            a_req = 1'b1; a_we = 1'($urandom_range(1, 0));
            a_addr = rand_addr(); a_wdata = 8'($urandom_range(255, 0));
         end
         if (!b_req && $urandom_range(2, 0) == 0) begin
            b_req = 1'b1; b_we = 1'($urandom_range(1, 0));
            b_addr = rand_addr(); b_wdata = 8'($urandom_range(255, 0));
         end
         if ($urandom_range(150, 0) == 0 && e != g_edge) do_reset(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
